// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response bundle for the data memory responder
interface data_mem_responder_if;
  logic        REQ_RD;
  logic        REQ_WR;
  logic [63:0] ADDR;
  logic [1:0]  SIZE;
  logic [63:0] WDATA;
  logic [63:0] RDATA;
  logic        READY;
  logic        BUSY;
  logic        ERR;

  modport master (
    output REQ_RD, REQ_WR, ADDR, SIZE, WDATA,
    input  RDATA, READY, BUSY, ERR
  );

  modport slave (
    input  REQ_RD, REQ_WR, ADDR, SIZE, WDATA,
    output RDATA, READY, BUSY, ERR
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding sized load/store responder with programmable wait states
// Accepts one request in IDLE, checks it, waits LATENCY cycles, then accesses a 64-bit-wide array.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, FAULT} state_t;

  state_t          state;
  logic [3:0]      count;
  logic            op_wr;
  logic [AW+2:0]   addr_q;
  logic [1:0]      size_q;
  logic [63:0]     wdata_q;
  logic [63:0]     rdata_q;
  logic            ready_q;
  logic            busy_q;
  logic            err_q;

  logic [63:0]     mem [DEPTH];

  logic            req;
  logic            conflict;
  logic            misaligned;
  logic            out_of_range;
  logic            reject;

  logic            acc_now;
  logic            acc_wr;
  logic [AW-1:0]   acc_idx;
  logic [2:0]      acc_lane;
  logic [1:0]      acc_size;
  logic [63:0]     acc_wdata;
  logic [63:0]     word;
  logic [63:0]     rd_shift;
  logic [63:0]     wr_shift;
  logic [63:0]     rd_val;
  logic [3:0]      nbytes;
  logic [7:0]      be;

  assign req          = bus.REQ_RD | bus.REQ_WR;
  assign conflict     = bus.REQ_RD & bus.REQ_WR;
  assign out_of_range = bus.ADDR[63:3] >= 61'(DEPTH);
  assign reject       = conflict | misaligned | out_of_range;

  always_comb begin
    misaligned = 1'b0;
    case (bus.SIZE)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.ADDR[0];
      2'b10:   misaligned = |bus.ADDR[1:0];
      default: misaligned = |bus.ADDR[2:0];
    endcase
  end

  // With LATENCY=0 the access happens on the accepting edge, so the live
  // request fields are used; otherwise the captured copies are.
  always_comb begin
    acc_now = 1'b0;
    if (state == IDLE)
      acc_now = (LATENCY == 0) && req && !reject;
    else if (state == WAIT)
      acc_now = (count == 4'd0);
  end

  assign acc_wr    = (state == IDLE) ? bus.REQ_WR           : op_wr;
  assign acc_idx   = (state == IDLE) ? bus.ADDR[AW+2:3]     : addr_q[AW+2:3];
  assign acc_lane  = (state == IDLE) ? bus.ADDR[2:0]        : addr_q[2:0];
  assign acc_size  = (state == IDLE) ? bus.SIZE             : size_q;
  assign acc_wdata = (state == IDLE) ? bus.WDATA            : wdata_q;

  assign nbytes   = 4'd1 << acc_size;
  assign word     = mem[acc_idx];
  assign rd_shift = word >> {acc_lane, 3'b000};
  assign wr_shift = acc_wdata << {acc_lane, 3'b000};

  always_comb begin
    be = 8'h00;
    for (int k = 0; k < 8; k++)
      be[k] = (4'(k) >= {1'b0, acc_lane}) && (4'(k) < ({1'b0, acc_lane} + nbytes));
  end

  always_comb begin
    rd_val = 64'd0;
    case (acc_size)
      2'b00:   rd_val = {{56{rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   rd_val = {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   rd_val = {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_val = rd_shift;
    endcase
  end

  // Array is deliberately not reset; only the addressed byte lanes are written.
  always_ff @(posedge CLK) begin
    if (acc_now && acc_wr) begin
      for (int k = 0; k < 8; k++)
        if (be[k])
          mem[acc_idx][8*k +: 8] <= wr_shift[8*k +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      count   <= 4'd0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_wr   <= bus.REQ_WR;
            addr_q  <= bus.ADDR[AW+2:0];
            size_q  <= bus.SIZE;
            wdata_q <= bus.WDATA;
            if (reject) begin
              state <= FAULT;
              err_q <= 1'b1;
            end else if (LATENCY == 0) begin
              state   <= RESP;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              if (!bus.REQ_WR)
                rdata_q <= rd_val;
            end else begin
              state  <= WAIT;
              count  <= 4'(LATENCY);
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state   <= RESP;
            ready_q <= 1'b1;
            if (!op_wr)
              rdata_q <= rd_val;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.RDATA = rdata_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = busy_q;
  assign bus.ERR   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed checks of data_mem_responder against a byte-array model
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  data_mem_responder_if b2();
  data_mem_responder_if b0();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (.CLK(CLK), .RST(RST), .bus(b2));
  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0))   u_dut0 (.CLK(CLK), .RST(RST), .bus(b0));

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mb [2][DEPTH*8];
  logic [63:0] last_rd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit fast, input bit rd, input bit wr, input logic [63:0] a,
                       input logic [1:0] s, input logic [63:0] d);
    if (fast) begin
      b0.REQ_RD = rd; b0.REQ_WR = wr; b0.ADDR = a; b0.SIZE = s; b0.WDATA = d;
    end else begin
      b2.REQ_RD = rd; b2.REQ_WR = wr; b2.ADDR = a; b2.SIZE = s; b2.WDATA = d;
    end
  endtask

  function automatic logic [63:0] model_read(input int f, input logic [63:0] a, input logic [1:0] s);
    int n;
    logic [63:0] v;
    n = 1 << s;
    v = 64'd0;
    for (int i = 0; i < n; i++)
      v = v | (64'(mb[f][int'(a) + i]) << (8 * i));
    if (n < 8 && v[8*n-1])
      v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic access(input bit fast, input bit rd, input bit wr, input logic [63:0] a,
                        input logic [1:0] s, input logic [63:0] d, input bit intrude,
                        input string tag, output logic [63:0] rd_out);
    int n, f, exp_k, ready_k, ready_cnt, err_k, err_cnt;
    bit fault;
    logic r, e, b, busy1;
    logic [63:0] got, q, expv;
    f = fast ? 1 : 0;
    n = 1 << s;
    fault = (rd && wr) || ((a % 64'(n)) != 64'd0) || ((a / 64'd8) >= 64'(DEPTH));
    exp_k = fast ? 1 : LAT + 2;
    ready_k = 0; ready_cnt = 0; err_k = 0; err_cnt = 0; busy1 = 1'b0; got = 64'd0;
    drive(fast, rd, wr, a, s, d);
    @(posedge CLK);
    #1;
    drive(fast, 1'b0, 1'b0, {$urandom, $urandom}, 2'($urandom), {$urandom, $urandom});
    b = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      r = fast ? b0.READY : b2.READY;
      e = fast ? b0.ERR   : b2.ERR;
      b = fast ? b0.BUSY  : b2.BUSY;
      q = fast ? b0.RDATA : b2.RDATA;
      if (k == 1) begin
        busy1 = b;
        got = q;
      end
      if (r) begin
        ready_cnt++;
        if (ready_k == 0) begin
          ready_k = k;
          got = q;
        end
      end
      if (e) begin
        err_cnt++;
        if (err_k == 0) err_k = k;
      end
      if (intrude && k == 1) drive(fast, 1'b0, 1'b1, 64'h30, 2'b11, 64'hBAD0_BAD0_BAD0_BAD0);
      if (intrude && k == 3) drive(fast, 1'b0, 1'b0, 64'h0, 2'b00, 64'h0);
    end
    if (!fault && rd) begin
      expv = model_read(f, a, s);
      last_rd[f] = expv;
    end else begin
      expv = last_rd[f];
    end
    if (!fault && wr)
      for (int i = 0; i < n; i++) mb[f][int'(a) + i] = d[8*i +: 8];
    check({tag, ".err_cnt"}, 64'(err_cnt), fault ? 64'd1 : 64'd0);
    check({tag, ".busy_end"}, 64'(b), 64'd0);
    if (fault) begin
      check({tag, ".err_cycle"}, 64'(err_k), 64'd1);
      check({tag, ".ready_cnt"}, 64'(ready_cnt), 64'd0);
      check({tag, ".busy"}, 64'(busy1), 64'd0);
    end else begin
      check({tag, ".ready_cycle"}, 64'(ready_k), 64'(exp_k));
      check({tag, ".ready_cnt"}, 64'(ready_cnt), 64'd1);
      check({tag, ".busy"}, 64'(busy1), 64'd1);
    end
    check({tag, ".rdata"}, got, expv);
    rd_out = got;
  endtask

  logic [63:0] res;

  initial begin
    bit rd, wr;
    logic [1:0] s;
    logic [63:0] a, d;
    int n, sel, rcnt;
    last_rd[0] = 64'd0;
    last_rd[1] = 64'd0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 64'h0);
    repeat (2) @(negedge CLK);
    check("reset.ready", 64'(b2.READY), 64'd0);
    check("reset.busy",  64'(b2.BUSY),  64'd0);
    check("reset.err",   64'(b2.ERR),   64'd0);
    check("reset.rdata", b2.RDATA,      64'd0);
    check("reset.rdata0", b0.RDATA,     64'd0);
    RST = 1'b0;
    @(negedge CLK);

    for (int w = 0; w < 16; w++) begin
      access(1'b0, 1'b0, 1'b1, 64'(w * 8), 2'b11, {$urandom, $urandom}, 1'b0, "prefill", res);
      access(1'b1, 1'b0, 1'b1, 64'(w * 8), 2'b11, {$urandom, $urandom}, 1'b0, "prefill0", res);
    end

    access(1'b0, 1'b0, 1'b1, 64'h10, 2'b11, 64'h8877665544332211, 1'b0, "dbl_wr", res);
    access(1'b0, 1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, "dbl_rd", res);
    check("dbl_rd.const", res, 64'h8877665544332211);
    access(1'b0, 1'b0, 1'b1, 64'h12, 2'b00, 64'hF0, 1'b0, "byte_wr", res);
    access(1'b0, 1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, "merge_rd", res);
    check("merge_rd.const", res, 64'h8877665544F02211);
    access(1'b0, 1'b1, 1'b0, 64'h12, 2'b00, 64'h0, 1'b0, "byte_rd", res);
    check("byte_rd.const", res, 64'hFFFFFFFFFFFFFFF0);
    access(1'b0, 1'b1, 1'b0, 64'h14, 2'b10, 64'h0, 1'b0, "word_rd", res);
    check("word_rd.const", res, 64'hFFFFFFFF88776655);

    access(1'b0, 1'b1, 1'b0, 64'h11, 2'b01, 64'h0, 1'b0, "misalign", res);
    access(1'b0, 1'b1, 1'b0, 64'h800, 2'b11, 64'h0, 1'b0, "range", res);
    access(1'b0, 1'b1, 1'b1, 64'h10, 2'b11, 64'hFFFF, 1'b0, "conflict", res);
    access(1'b0, 1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, "after_faults", res);
    check("after_faults.const", res, 64'h8877665544F02211);

    access(1'b0, 1'b0, 1'b1, 64'h18, 2'b11, 64'h0123_4567_89AB_CDEF, 1'b1, "intrude", res);
    access(1'b0, 1'b1, 1'b0, 64'h30, 2'b11, 64'h0, 1'b0, "intrude_target", res);
    access(1'b0, 1'b1, 1'b0, 64'h18, 2'b11, 64'h0, 1'b0, "intrude_first", res);
    check("intrude_first.const", res, 64'h0123_4567_89AB_CDEF);

    access(1'b0, 1'b0, 1'b1, 64'h20, 2'b11, 64'h1234, 1'b0, "abort_pre", res);
    drive(1'b0, 1'b0, 1'b1, 64'h20, 2'b11, 64'hDEAD);
    @(posedge CLK);
    #1;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 64'h0);
    @(negedge CLK);
    check("abort.busy_wait", 64'(b2.BUSY), 64'd1);
    RST = 1'b1;
    #1;
    check("abort.busy_rst", 64'(b2.BUSY), 64'd0);
    check("abort.rdata_rst", b2.RDATA, 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    last_rd[0] = 64'd0;
    last_rd[1] = 64'd0;
    rcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (b2.READY) rcnt++;
    end
    check("abort.ready_cnt", 64'(rcnt), 64'd0);
    check("abort.busy", 64'(b2.BUSY), 64'd0);
    check("abort.rdata", b2.RDATA, 64'd0);
    access(1'b0, 1'b1, 1'b0, 64'h20, 2'b11, 64'h0, 1'b0, "abort_rd", res);
    check("abort_rd.const", res, 64'h1234);

    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      rd = (sel == 0) ? 1'b1 : sel[0];
      wr = (sel == 0) ? 1'b1 : ~sel[0];
      s = 2'($urandom);
      n = 1 << s;
      sel = $urandom_range(0, 9);
      if (sel == 0) a = 64'h800 + 64'(8 * $urandom_range(0, 100));
      else if (sel == 1) a = 64'($urandom_range(0, 127));
      else a = 64'($urandom_range(0, 127)) & ~64'(n - 1);
      d = {$urandom, $urandom};
      access(1'b0, rd, wr, a, s, d, 1'b0, "rand", res);
    end

    access(1'b1, 1'b0, 1'b1, 64'h40, 2'b11, 64'hFEDC_BA98_7654_3210, 1'b0, "l0_wr", res);
    access(1'b1, 1'b1, 1'b0, 64'h40, 2'b11, 64'h0, 1'b0, "l0_rd", res);
    check("l0_rd.const", res, 64'hFEDC_BA98_7654_3210);
    access(1'b1, 1'b1, 1'b0, 64'h46, 2'b01, 64'h0, 1'b0, "l0_half", res);
    check("l0_half.const", res, 64'hFFFF_FFFF_FFFF_FEDC);
    access(1'b1, 1'b1, 1'b0, 64'h43, 2'b01, 64'h0, 1'b0, "l0_misalign", res);
    for (int it = 0; it < 20; it++) begin
      sel = $urandom_range(0, 1);
      s = 2'($urandom);
      n = 1 << s;
      a = 64'($urandom_range(0, 127)) & ~64'(n - 1);
      access(1'b1, sel[0], ~sel[0], a, s, {$urandom, $urandom}, 1'b0, "l0_rand", res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
